// File: rtl/uv_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uv_uart_pkg
//  Description : Types and constants for the memory-mapped UART transmitter.
//                Contents: the transmit FSM state type, the register word
//                offsets, the STATUS bit positions, the frame length and an
//                even-parity helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uv_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Register word offsets within the peripheral slot
    localparam logic [1:0] c_addr_txdata = 2'd0;
    localparam logic [1:0] c_addr_status = 2'd1;
    localparam logic [1:0] c_addr_ctrl   = 2'd2;

    // STATUS register bit positions
    localparam int c_stat_busy    = 0;
    localparam int c_stat_empty   = 1;
    localparam int c_stat_full    = 2;
    localparam int c_stat_ovf     = 3;
    localparam int c_stat_cnt_lsb = 8;

    // Bits per 8E1 frame: start + 8 data + parity + stop
    localparam int c_frame_bits = 11;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO, WIDTH bits wide and DEPTH entries deep.
//                DEPTH must be a power of two so the pointers wrap naturally.
//                A push while full and a pop while empty are ignored.
//  Ports       : clk, rst (async, active high)
//                push / push_data  - write one entry
//                pop  / pop_data   - pop_data shows the head, pop removes it
//                full, empty, count (entries held, $clog2(DEPTH)+1 bits)
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_cw'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_mmio
//  Description : Memory-mapped 8E1 UART transmitter with a transmit FIFO.
//                Stores to TXDATA queue a byte; the FSM serialises queued
//                bytes back-to-back. STATUS/CTRL are read combinationally.
//  Ports       : clk, rst (async, active high)
//                in_write_en, in_address[1:0], in_data[31:0]  - store path
//                out_read_data[31:0]                          - read mux
//                serial_tx (idles high), tx_done (end of stop bit),
//                fifo_full
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_mmio
    import uv_uart_pkg::*;
#(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_write_en,
    input  logic [1:0]  in_address,
    input  logic [31:0] in_data,
    output logic [31:0] out_read_data,
    output logic        serial_tx,
    output logic        tx_done,
    output logic        fifo_full
);

    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;
    localparam int c_bw = $clog2(BAUD_DIV);
    localparam logic [c_bw-1:0] c_baud_last = c_bw'(BAUD_DIV - 1);
    localparam logic [c_bw-1:0] c_done_at   = c_bw'(BAUD_DIV - 2);

    tx_state_t       r_state;
    logic [c_bw-1:0] r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_data;
    logic            r_overflow;

    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_head;
    logic            w_full;
    logic            w_empty;
    logic [c_cw-1:0] w_count;
    logic            w_baud_last;
    logic            w_wr_tx;
    logic            w_wr_ctrl;
    logic            w_unused_data;

    assign w_unused_data = ^in_data[31:8];

    assign w_wr_tx     = in_write_en && (in_address == c_addr_txdata);
    assign w_wr_ctrl   = in_write_en && (in_address == c_addr_ctrl);
    assign w_push      = w_wr_tx && !w_full;
    assign w_baud_last = (r_baud == c_baud_last);
    // A pop happens when leaving IDLE or at the very end of a stop bit
    assign w_pop       = !w_empty &&
                         ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_last));
    assign fifo_full   = w_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (in_data[7:0]),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Overflow is judged on the pre-edge fill level; a same-cycle pop does
    // not make room for the store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_wr_tx && w_full) begin
            r_overflow <= 1'b1;
        end else if (w_wr_ctrl && in_data[0]) begin
            r_overflow <= 1'b0;
        end
    end

    // serial_tx always carries the level of the state being entered, so the
    // line changes on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_data    <= '0;
            serial_tx <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_data    <= w_head;
                        r_state   <= ST_START;
                        serial_tx <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_bit     <= '0;
                        r_state   <= ST_DATA;
                        serial_tx <= r_data[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state   <= ST_PARITY;
                            serial_tx <= even_parity(r_data);
                        end else begin
                            r_bit     <= r_bit + 1'b1;
                            serial_tx <= r_data[r_bit + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_state   <= ST_STOP;
                        serial_tx <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_data    <= w_head;
                            r_state   <= ST_START;
                            serial_tx <= 1'b0;
                        end else begin
                            r_state   <= ST_IDLE;
                            serial_tx <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                        // Raise one cycle early so the pulse lands on the
                        // final stop-bit cycle
                        if (r_baud == c_done_at) begin
                            tx_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_baud    <= '0;
                    serial_tx <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        out_read_data = '0;
        case (in_address)
            c_addr_status: begin
                out_read_data[c_stat_busy]            = (r_state != ST_IDLE);
                out_read_data[c_stat_empty]           = w_empty;
                out_read_data[c_stat_full]            = w_full;
                out_read_data[c_stat_ovf]             = r_overflow;
                out_read_data[c_stat_cnt_lsb +: 8]    = 8'(w_count);
            end
            c_addr_ctrl: begin
                out_read_data[0] = r_overflow;
            end
            default: begin
                out_read_data = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that acts as a bus responder to the processor core's store path. Stores to its data register are queued in a small FIFO, and each byte is serialised as an 8E1 frame: start, 8 data bits LSB first, even parity, stop. It occupies one peripheral slot of the top-level memory decoder. It returns status through the decoder's read-data mux, so firmware can poll for space instead of busy-waiting on a single-byte transmitter.

## Interface
- BAUD_DIV, 434: clock cycles per serial bit (50 MHz / 115200); minimum 2
- FIFO_DEPTH, 8: transmit FIFO entries; power of two, at least 2
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_write_en  in  1  store strobe from the decoder slot, one cycle per store
- in_address  in  2  word offset: 0 = TXDATA, 1 = STATUS, 2 = CTRL
- in_data  in  32  store data; only [7:0] is used
- out_read_data  out  32  combinational read of the selected register
- serial_tx  out  1  UART line; idles high
- tx_done  out  1  one-cycle pulse at the end of each stop bit
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes

## Operation
- Write to TXDATA:
  - If the FIFO count is below FIFO_DEPTH before the edge, in_data[7:0] is pushed.
  - Otherwise the byte is dropped and sticky overflow is set.
  - There is no exemption when a pop happens in the same cycle.
- Write to CTRL with in_data[0]=1 clears overflow. Writes to STATUS, and writes to offset 3, are ignored.
- STATUS read format:
  - [0] busy (state != IDLE)
  - [1] fifo_empty
  - [2] fifo_full
  - [3] overflow
  - [15:8] FIFO count
  - all other bits 0
- Reading TXDATA or offset 3 returns 0. Reading CTRL returns {31'b0, overflow}.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. The head byte is popped into the shift register on the same edge.
  - START: serial_tx=0 for BAUD_DIV cycles → DATA.
  - DATA: shift out 8 bits LSB first, BAUD_DIV cycles each; a 3-bit bit counter reaches 7 → PARITY.
  - PARITY: serial_tx = XOR of the 8 data bits (even parity) for BAUD_DIV cycles → STOP.
  - STOP: serial_tx=1 for BAUD_DIV cycles. On its last cycle tx_done=1. The next state is START (with a pop) if the FIFO is non-empty, else IDLE. Frames run back-to-back with no idle gap.
- The baud counter counts 0..BAUD_DIV-1. It reloads on every state change and is held at 0 in IDLE.
- Parity is computed from the latched shift-register copy, not from the FIFO.
- Reset:
  - state IDLE, FIFO emptied (count 0), overflow 0.
  - serial_tx=1, tx_done=0, fifo_full=0.
  - A reset in the middle of a frame aborts it immediately; the line returns high asynchronously.

## Timing
- Store at edge N: the byte is in the FIFO after N.
- If idle, the FSM pops at edge N+1 and serial_tx falls just after N+1.
- One frame lasts 11·BAUD_DIV cycles.
- tx_done is high for the cycle that ends the frame, aligned with the final stop-bit cycle.
- Register outputs: serial_tx, tx_done and the FSM outputs are registered. out_read_data is combinational from registers plus in_address, so the core sees it in the same cycle.
- Push and pop in the same cycle:
  - If the FIFO is not full, both take effect and the count is unchanged.
  - If the FIFO is full, only the pop happens and the push sets overflow.
- Pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.

## Structure
- The shared package uv_uart_pkg holds:
  - the FSM state enum
  - register offsets TXDATA/STATUS/CTRL
  - STATUS bit positions
  - the frame length constant (11)
- One natural sub-module: sync_fifo. It is parameterised by width and depth and provides push, pop, full, empty and count. It can be reused later for an RX buffer.

## Test plan
- After reset, bench BAUD_DIV=4, FIFO_DEPTH=4:
  - serial_tx=1 and STATUS reads 0x00000002.
  - 20 idle cycles: no toggle on serial_tx.
- Write 0x55 to TXDATA:
  - serial_tx shows 0,1,0,1,0,1,0,1,0 (parity 0),1. Each bit lasts 4 cycles, 44 cycles total.
  - One tx_done pulse.
  - STATUS returns 0x00000002.
- Write 0xA7 then 0x00 on consecutive cycles:
  - The two frames are contiguous, with no high gap after the first stop bit.
  - Parity bits are 1 then 0.
  - Two tx_done pulses 44 cycles apart.
- Write 6 bytes in 6 consecutive cycles while idle:
  - 1 is popped and 4 are queued, so 5 are transmitted.
  - The sixth write sets overflow. STATUS[3]=1 and count=4 right after the writes.
  - Writing CTRL=1 clears STATUS[3].
- Assert rst 20 cycles into a frame:
  - serial_tx goes high with no clock edge.
  - After release, count=0, no further frame is sent, and tx_done stays 0.
